// File: rtl/obstacle_lane_scheduler.sv
// Game-flow controller: sequences IDLE/PLAY/LEVEL_UP/CRASH, paces car motion with a
// score-dependent step enable and picks a fresh lane-direction pattern on every level-up.
module obstacle_lane_scheduler #(
    parameter int unsigned C_BASE_CAR_SPEED = 781250,
    parameter int unsigned NUM_LANES        = 4,
    parameter int unsigned C_FREEZE_CYCLES  = 25000000,
    parameter logic [7:0]  C_LFSR_SEED      = 8'hA5
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic                 i_Goal,
    input  logic                 i_Collision,
    input  logic                 i_Pause,
    output logic [1:0]           o_State,
    output logic                 o_Tick,
    output logic [NUM_LANES-1:0] o_Reverse,
    output logic                 o_Level_Up,
    output logic [3:0]           o_Score
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PLAY     = 2'd1,
        S_LEVEL_UP = 2'd2,
        S_CRASH    = 2'd3
    } state_t;

    localparam logic [19:0] PERIOD_T0   = 20'(C_BASE_CAR_SPEED);
    localparam logic [19:0] PERIOD_T1   = PERIOD_T0 >> 1;
    localparam logic [19:0] PERIOD_T2   = PERIOD_T0 >> 2;
    localparam logic [19:0] PERIOD_T3   = PERIOD_T0 >> 3;
    localparam logic [24:0] FREEZE_LAST = 25'(C_FREEZE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [19:0]            step_q, step_d;
    logic [24:0]            freeze_q, freeze_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic                   tick_q, tick_d;
    logic                   level_up_q, level_up_d;
    logic [3:0]             score_q, score_d;
    logic [NUM_LANES-1:0]   reverse_q, reverse_d;
    logic [19:0]            period_last;
    logic [NUM_LANES-1:0]   new_reverse;

    always_comb begin
        if (score_q <= 4'd3) begin
            period_last = PERIOD_T0 - 20'd1;
        end else if (score_q <= 4'd6) begin
            period_last = PERIOD_T1 - 20'd1;
        end else if (score_q <= 4'd9) begin
            period_last = PERIOD_T2 - 20'd1;
        end else begin
            period_last = PERIOD_T3 - 20'd1;
        end
    end

    // A repeated pattern would leave the road looking unchanged, so force bit 0 over.
    always_comb begin
        new_reverse = lfsr_q[NUM_LANES-1:0];
        if (new_reverse == reverse_q) begin
            new_reverse[0] = ~new_reverse[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        freeze_d   = freeze_q;
        tick_d     = 1'b0;
        level_up_d = 1'b0;
        score_d    = score_q;
        reverse_d  = reverse_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE: begin
                score_d   = 4'd0;
                reverse_d = '0;
                if (i_Start) begin
                    state_d = S_PLAY;
                    step_d  = 20'd0;
                end
            end
            S_PLAY: begin
                if (i_Collision) begin
                    state_d  = S_CRASH;
                    freeze_d = 25'd0;
                end else if (i_Goal) begin
                    state_d    = S_LEVEL_UP;
                    freeze_d   = 25'd0;
                    score_d    = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
                    reverse_d  = new_reverse;
                    level_up_d = 1'b1;
                end else if (!i_Pause) begin
                    // >= rather than == so a period that shrank mid-count still fires.
                    if (step_q >= period_last) begin
                        tick_d = 1'b1;
                        step_d = 20'd0;
                    end else begin
                        step_d = step_q + 20'd1;
                    end
                end
            end
            S_LEVEL_UP, S_CRASH: begin
                if (!i_Pause) begin
                    if (freeze_q == FREEZE_LAST) begin
                        freeze_d = 25'd0;
                        if (state_q == S_LEVEL_UP) begin
                            state_d = S_PLAY;
                            step_d  = 20'd0;
                        end else begin
                            state_d   = S_IDLE;
                            score_d   = 4'd0;
                            reverse_d = '0;
                        end
                    end else begin
                        freeze_d = freeze_q + 25'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            step_q     <= 20'd0;
            freeze_q   <= 25'd0;
            lfsr_q     <= C_LFSR_SEED;
            tick_q     <= 1'b0;
            level_up_q <= 1'b0;
            score_q    <= 4'd0;
            reverse_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            freeze_q   <= freeze_d;
            lfsr_q     <= lfsr_d;
            tick_q     <= tick_d;
            level_up_q <= level_up_d;
            score_q    <= score_d;
            reverse_q  <= reverse_d;
        end
    end

    assign o_State    = state_q;
    assign o_Tick     = tick_q;
    assign o_Reverse  = reverse_q;
    assign o_Level_Up = level_up_q;
    assign o_Score    = score_q;

endmodule

// File: tb/tb_obstacle_lane_scheduler.sv
// Scenario bench for obstacle_lane_scheduler with small timing parameters; expected ticks
// and level-up results are queued when stimulus is driven and popped when the DUT responds.
module tb_obstacle_lane_scheduler;

    localparam int BASE   = 16;
    localparam int LANES  = 4;
    localparam int FREEZE = 8;

    logic             i_Clk = 1'b0;
    logic             i_Reset = 1'b1;
    logic             i_Start = 1'b0;
    logic             i_Goal = 1'b0;
    logic             i_Collision = 1'b0;
    logic             i_Pause = 1'b0;
    logic [1:0]       o_State;
    logic             o_Tick;
    logic [LANES-1:0] o_Reverse;
    logic             o_Level_Up;
    logic [3:0]       o_Score;

    obstacle_lane_scheduler #(
        .C_BASE_CAR_SPEED(BASE),
        .NUM_LANES(LANES),
        .C_FREEZE_CYCLES(FREEZE),
        .C_LFSR_SEED(8'hA5)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Start(i_Start),
        .i_Goal(i_Goal),
        .i_Collision(i_Collision),
        .i_Pause(i_Pause),
        .o_State(o_State),
        .o_Tick(o_Tick),
        .o_Reverse(o_Reverse),
        .o_Level_Up(o_Level_Up),
        .o_Score(o_Score)
    );

    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, advancing every clock.
    logic [7:0] lfsr_m;
    always @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) lfsr_m <= 8'hA5;
        else         lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    int check_cnt = 0;
    int pass_cnt = 0;
    int exp_tick_q[$];
    logic [3:0] exp_score_q[$];
    logic [LANES-1:0] exp_rev_q[$];
    logic [3:0] score_m = 4'd0;
    logic [LANES-1:0] rev_m = '0;

    task automatic wait_tick(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_Clk);
            if (o_Tick === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic wait_leave(input logic [1:0] st, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge i_Clk);
            if (o_State !== st) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Drive a goal from PLAY, queue the expected score/pattern, then verify the full freeze.
    task automatic level_up_once(input string tag, output int entry);
        logic [LANES-1:0] er;
        logic [LANES-1:0] old_rev;
        logic [3:0] es;
        logic [3:0] got_s;
        logic [LANES-1:0] got_r;
        int bad;
        er = lfsr_m[LANES-1:0];
        if (er == rev_m) er[0] = ~er[0];
        es = (score_m == 4'd15) ? 4'd15 : score_m + 4'd1;
        exp_rev_q.push_back(er);
        exp_score_q.push_back(es);
        old_rev = rev_m;
        i_Goal = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        check_cnt++;
        if ({o_State, o_Level_Up} !== {2'd2, 1'b1})
            $display("FAIL %s_enter: got state=%0d lvl=%0b want state=2 lvl=1", tag, o_State, o_Level_Up);
        else pass_cnt++;
        got_s = exp_score_q.pop_front();
        got_r = exp_rev_q.pop_front();
        check_cnt++;
        if (o_Score !== got_s) $display("FAIL %s_score: got %0d want %0d", tag, o_Score, got_s);
        else pass_cnt++;
        check_cnt++;
        if (o_Reverse !== got_r) $display("FAIL %s_rev: got %h want %h", tag, o_Reverse, got_r);
        else pass_cnt++;
        check_cnt++;
        if (o_Reverse === old_rev) $display("FAIL %s_rev_changed: got %h want not %h", tag, o_Reverse, old_rev);
        else pass_cnt++;
        score_m = es;
        rev_m = er;
        $display("level_up %s: score=%0d reverse=%h", tag, o_Score, o_Reverse);
        bad = 0;
        for (int k = 1; k < FREEZE; k++) begin
            @(negedge i_Clk);
            if (o_State !== 2'd2 || o_Level_Up !== 1'b0 || o_Tick !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL %s_freeze: got %0d bad cycles want 0", tag, bad);
        else pass_cnt++;
        @(negedge i_Clk);
        check_cnt++;
        if (o_State !== 2'd1) $display("FAIL %s_return: got state %0d want 1", tag, o_State);
        else pass_cnt++;
        entry = cyc;
    endtask

    task automatic test_reset();
        int ent, at, ex;
        i_Reset = 1'b1;
        repeat (3) @(negedge i_Clk);
        check_cnt++;
        if ({o_State, o_Tick, o_Reverse, o_Level_Up, o_Score} !== 12'h000)
            $display("FAIL reset_init: got %h want 000", {o_State, o_Tick, o_Reverse, o_Level_Up, o_Score});
        else pass_cnt++;
        i_Reset = 1'b0;
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        check_cnt++;
        if (o_State !== 2'd1) $display("FAIL reset_start1: got state %0d want 1", o_State);
        else pass_cnt++;
        repeat (7) @(negedge i_Clk);
        #2 i_Reset = 1'b1;
        #1;
        check_cnt++;
        if ({o_State, o_Tick, o_Reverse, o_Level_Up, o_Score} !== 12'h000)
            $display("FAIL reset_async: got %h want 000", {o_State, o_Tick, o_Reverse, o_Level_Up, o_Score});
        else pass_cnt++;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        score_m = 4'd0;
        rev_m = '0;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        ent = cyc;
        check_cnt++;
        if (o_State !== 2'd1) $display("FAIL reset_start2: got state %0d want 1", o_State);
        else pass_cnt++;
        for (int k = 1; k <= 3; k++) exp_tick_q.push_back(ent + k * BASE);
        for (int k = 0; k < 3; k++) begin
            wait_tick(3 * BASE, at);
            ex = exp_tick_q.pop_front();
            check_cnt++;
            if (at !== ex) $display("FAIL reset_tick%0d: got cycle %0d want %0d", k, at, ex);
            else pass_cnt++;
            $display("tick at cycle %0d (entry %0d)", at, ent);
        end
    endtask

    task automatic test_goals();
        int ent, at, ex;
        for (int g = 1; g <= 4; g++) level_up_once($sformatf("goal%0d", g), ent);
        exp_tick_q.push_back(ent + 8);
        exp_tick_q.push_back(ent + 16);
        for (int k = 0; k < 2; k++) begin
            wait_tick(3 * BASE, at);
            ex = exp_tick_q.pop_front();
            check_cnt++;
            if (at !== ex) $display("FAIL goals_tick%0d: got cycle %0d want %0d", k, at, ex);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturate();
        int ent, at, ex;
        for (int g = 5; g <= 10; g++) level_up_once($sformatf("goal%0d", g), ent);
        for (int k = 1; k <= 3; k++) exp_tick_q.push_back(ent + 2 * k);
        for (int k = 0; k < 3; k++) begin
            wait_tick(3 * BASE, at);
            ex = exp_tick_q.pop_front();
            check_cnt++;
            if (at !== ex) $display("FAIL sat_tick%0d: got cycle %0d want %0d", k, at, ex);
            else pass_cnt++;
        end
        for (int g = 11; g <= 16; g++) level_up_once($sformatf("goal%0d", g), ent);
        check_cnt++;
        if (o_Score !== 4'd15) $display("FAIL sat_score: got %0d want 15", o_Score);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        int at, bad;
        i_Goal = 1'b1;
        i_Collision = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        i_Collision = 1'b0;
        check_cnt++;
        if ({o_State, o_Level_Up, o_Score} !== {2'd3, 1'b0, score_m})
            $display("FAIL crash_enter: got state=%0d lvl=%0b score=%0d want state=3 lvl=0 score=%0d",
                     o_State, o_Level_Up, o_Score, score_m);
        else pass_cnt++;
        at = -1;
        bad = 0;
        for (int i = 0; i < 3 * FREEZE; i++) begin
            @(negedge i_Clk);
            if (o_Tick !== 1'b0 || o_Level_Up !== 1'b0) bad++;
            if (o_State !== 2'd3) begin
                at = i + 1;
                break;
            end
        end
        check_cnt++;
        if (at !== FREEZE || bad !== 0) $display("FAIL crash_len: got %0d cycles (%0d bad) want %0d", at, bad, FREEZE);
        else pass_cnt++;
        check_cnt++;
        if ({o_State, o_Score, o_Reverse} !== 10'h000)
            $display("FAIL crash_idle: got state=%0d score=%0d rev=%h want all 0", o_State, o_Score, o_Reverse);
        else pass_cnt++;
        score_m = 4'd0;
        rev_m = '0;
        $display("crash complete: state=%0d score=%0d", o_State, o_Score);
    endtask

    task automatic test_pause();
        int r, at, ex, bad, n0;
        logic [LANES-1:0] er;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (5) @(negedge i_Clk);
        i_Pause = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge i_Clk);
            if (o_Tick !== 1'b0) bad++;
        end
        i_Pause = 1'b0;
        r = cyc;
        check_cnt++;
        if (bad !== 0) $display("FAIL pause_hold: got %0d ticks want 0", bad);
        else pass_cnt++;
        exp_tick_q.push_back(r + 11);
        wait_tick(3 * BASE, at);
        ex = exp_tick_q.pop_front();
        check_cnt++;
        if (at !== ex) $display("FAIL pause_resume_tick: got cycle %0d want %0d", at, ex);
        else pass_cnt++;
        er = lfsr_m[LANES-1:0];
        if (er == rev_m) er[0] = ~er[0];
        exp_rev_q.push_back(er);
        exp_score_q.push_back(score_m + 4'd1);
        i_Goal = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        n0 = cyc;
        score_m = exp_score_q.pop_front();
        rev_m = exp_rev_q.pop_front();
        check_cnt++;
        if ({o_State, o_Level_Up, o_Score, o_Reverse} !== {2'd2, 1'b1, score_m, rev_m})
            $display("FAIL pause_lvl_enter: got state=%0d lvl=%0b score=%0d rev=%h want 2 1 %0d %h",
                     o_State, o_Level_Up, o_Score, o_Reverse, score_m, rev_m);
        else pass_cnt++;
        repeat (3) @(negedge i_Clk);
        i_Pause = 1'b1;
        repeat (10) @(negedge i_Clk);
        i_Pause = 1'b0;
        wait_leave(2'd2, 4 * FREEZE, at);
        check_cnt++;
        if (at - n0 !== FREEZE + 10 || o_State !== 2'd1)
            $display("FAIL pause_freeze: got %0d cycles state=%0d want %0d state=1", at - n0, o_State, FREEZE + 10);
        else pass_cnt++;
    endtask

    task automatic test_ignore();
        int n0, at, bad;
        logic [LANES-1:0] er;
        er = lfsr_m[LANES-1:0];
        if (er == rev_m) er[0] = ~er[0];
        exp_rev_q.push_back(er);
        exp_score_q.push_back(score_m + 4'd1);
        i_Goal = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        n0 = cyc;
        score_m = exp_score_q.pop_front();
        rev_m = exp_rev_q.pop_front();
        bad = 0;
        @(negedge i_Clk);
        i_Goal = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        i_Collision = 1'b1;
        @(negedge i_Clk);
        i_Collision = 1'b0;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        if (o_Level_Up !== 1'b0) bad++;
        wait_leave(2'd2, 4 * FREEZE, at);
        check_cnt++;
        if (at - n0 !== FREEZE || o_State !== 2'd1)
            $display("FAIL ignore_len: got %0d cycles state=%0d want %0d state=1", at - n0, o_State, FREEZE);
        else pass_cnt++;
        check_cnt++;
        if (o_Score !== score_m || o_Reverse !== rev_m || bad !== 0)
            $display("FAIL ignore_hold: got score=%0d rev=%h lvl_extra=%0d want score=%0d rev=%h 0",
                     o_Score, o_Reverse, bad, score_m, rev_m);
        else pass_cnt++;
    endtask

    task automatic test_reset_late();
        i_Goal = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        #2 i_Reset = 1'b1;
        #1;
        check_cnt++;
        if ({o_State, o_Tick, o_Reverse, o_Level_Up, o_Score} !== 12'h000)
            $display("FAIL reset_late: got %h want 000", {o_State, o_Tick, o_Reverse, o_Level_Up, o_Score});
        else pass_cnt++;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        i_Goal = 1'b1;
        i_Collision = 1'b1;
        @(negedge i_Clk);
        i_Goal = 1'b0;
        i_Collision = 1'b0;
        @(negedge i_Clk);
        check_cnt++;
        if ({o_State, o_Score, o_Level_Up} !== 7'h00)
            $display("FAIL idle_ignore: got state=%0d score=%0d lvl=%0b want 0 0 0", o_State, o_Score, o_Level_Up);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_goals();
        test_saturate();
        test_collision();
        test_pause();
        test_ignore();
        test_reset_late();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
